regfile_scoreboard: RTL



---
 rtl/rv_pkg.sv | 26 ++
 rtl/regfile_core.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared rv32 pipeline definitions: widths, register index type and
// write-back select encodings used across the integer datapath.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;
  localparam int CW   = 2;

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_CSR = 2'd3
  } wb_valD_sel_e;

  // True when an enabled port targets the given register index.
  function automatic logic idx_hit(input logic en, input reg_idx_t a, input reg_idx_t b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: one write port, two bypassed decode
// read ports and an unbypassed debug read port.
module regfile_core #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [1:0][AW-1:0]   raddr,
  output logic [1:0][XLEN-1:0] rdata,
  input  logic [AW-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data
);
  import rv_pkg::*;

  logic [XLEN-1:0] regs_q [NREG];

  // x0 is never written after reset, so it holds zero permanently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs_q[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rport
    assign rdata[gi] = (raddr[gi] == REG_ZERO)           ? '0    :
                       idx_hit(we, waddr, raddr[gi])     ? wdata :
                                                           regs_q[raddr[gi]];
  end

  assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write counters that
// produce the decode RAW-hazard / counter-full stall.
module regfile_scoreboard #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW,
  parameter int CW   = rv_pkg::CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_reg_wen,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_valD,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            issue_valid,
  input  logic            issue_rd_wen,
  input  logic [AW-1:0]   issue_rd,
  input  logic            sq0_valid,
  input  logic            sq1_valid,
  input  logic [AW-1:0]   sq0_rd,
  input  logic [AW-1:0]   sq1_rd,
  output logic            stall,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  import rv_pkg::*;

  localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};

  logic [CW-1:0]        pend_q [NREG];
  logic [CW-1:0]        pend_d [NREG];
  logic [NREG-1:0]      uflow;
  logic                 err_underflow_q;
  logic [1:0][AW-1:0]   rs_idx;
  logic [1:0]           rs_used;
  logic [1:0]           busy;
  logic [1:0][XLEN-1:0] core_rdata;
  logic                 full;
  logic                 issue_ok;

  regfile_core #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_reg_wen),
    .waddr    (wb_rd),
    .wdata    (wb_valD),
    .raddr    (rs_idx),
    .rdata    (core_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign rs_idx  = {rs2, rs1};
  assign rs_used = {rs2_used, rs1_used};
  assign rdata1  = core_rdata[0];
  assign rdata2  = core_rdata[1];

  // A write-back landing this cycle retires one pending write and is
  // already visible through the read bypass.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
    logic [CW:0] pend_rs;
    logic        wb_hit;
    assign pend_rs  = {1'b0, pend_q[rs_idx[gi]]};
    assign wb_hit   = idx_hit(wb_reg_wen, wb_rd, rs_idx[gi]);
    assign busy[gi] = rs_used[gi] && (rs_idx[gi] != REG_ZERO) &&
                      (pend_rs > (CW+1)'(wb_hit));
  end

  assign full     = issue_rd_wen && (issue_rd != REG_ZERO) && (pend_q[issue_rd] == PEND_MAX);
  assign stall    = (|busy) || full;
  assign issue_ok = issue_valid && issue_rd_wen && !stall;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    if (gi == 0) begin : g_x0
      assign pend_d[gi] = '0;
      assign uflow[gi]  = 1'b0;
    end else begin : g_rn
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic        inc;
      logic [CW:0] tot;
      logic [CW:0] dec;
      logic [CW:0] diff;
      assign inc  = issue_ok && (issue_rd == IDX);
      assign tot  = {1'b0, pend_q[gi]} + (CW+1)'(inc);
      assign dec  = (CW+1)'(idx_hit(wb_reg_wen, wb_rd, IDX)) +
                    (CW+1)'(idx_hit(sq0_valid, sq0_rd, IDX)) +
                    (CW+1)'(idx_hit(sq1_valid, sq1_rd, IDX));
      assign diff = tot - dec;
      assign uflow[gi]  = (tot < dec);
      assign pend_d[gi] = (tot < dec)              ? '0       :
                          (diff > {1'b0, PEND_MAX}) ? PEND_MAX :
                                                      diff[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= '0;
      end
      err_underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= pend_d[i];
      end
      err_underflow_q <= err_underflow_q || (|uflow);
    end
  end

  // Squashes may only target registers with an outstanding write.
  sq0_has_pending_a: assert property (@(posedge clk) disable iff (!rst_n)
    sq0_valid |-> (pend_q[sq0_rd] != '0));
  sq1_has_pending_a: assert property (@(posedge clk) disable iff (!rst_n)
    sq1_valid |-> (pend_q[sq1_rd] != '0));
  underflow_seen_c: cover property (@(posedge clk) err_underflow_q);

endmodule
